systolic_input_skewer: RTL

//  Feeds the left edge of the processing-element array.
//  - Accepts one column of A per beat (ROWS lanes, one per array row) and buffers up to DEPTH columns.
//  - Issues buffered columns with diagonal skew: row r is delayed r cycles, so row r reaches its PE one cycle after row r-1.
//  - Drives each row's a_in and valid so the array computes a matrix product without external scheduling.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/skew_delay_line.sv | 53 +++++
 rtl/systolic_input_skewer.sv | 106 ++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU definitions used by the PE array top and its edge feeders.
//   TPU_DATA_W : default operand width (PE a_in width)
//   TPU_ROWS   : default number of PE array rows
//   ptr_width  : pointer width for a power-of-two buffer depth (min 1)
package tpu_pkg;

  localparam int unsigned TPU_DATA_W = 8;
  localparam int unsigned TPU_ROWS   = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// One row of the input skew: a STAGES-deep shift register of {valid, data}.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : advance the line (hold when low)
//   clr_i         : synchronous clear, wins over en_i
//   valid_i/data_i: entry into stage 0
//   valid_o/data_o: last stage
//   busy_o        : any stage holds a valid entry
module skew_delay_line #(
  parameter int unsigned STAGES = 1,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] data_d [STAGES];

  always_comb begin
    valid_d[0] = valid_i;
    data_d[0]  = data_i;
    for (int unsigned i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (clr_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= data_d[i];
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign data_o  = data_q[STAGES-1];
  assign busy_o  = |valid_q;

endmodule

// File: rtl/systolic_input_skewer.sv
// Left-edge feeder of the PE array: buffers columns of A and issues them
// with diagonal skew (row r delayed r cycles behind row 0).
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_data : column input, lane r at [r*DATA_W +: DATA_W]
//   run   : advance FIFO output and skew stages; 0 freezes them
//   flush : synchronous clear of FIFO and skew stages
//   a_out/valid_out : per-row operand and valid to PE column 0
//   busy  : FIFO non-empty or any skew stage valid
module systolic_input_skewer
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS   = TPU_ROWS,
  parameter int unsigned DATA_W = TPU_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   run,
  input  logic                   flush,
  output logic [ROWS*DATA_W-1:0] a_out,
  output logic [ROWS-1:0]        valid_out,
  output logic                   busy
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ROWS*DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic full, empty, push, pop;
  logic [ROWS*DATA_W-1:0] col_data;
  logic [ROWS-1:0]        row_busy;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  // in_ready reflects the registered state only, so it still shows the
  // pre-flush value during a flush cycle.
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;
  assign pop      = run && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage contents are qualified by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Without a pop, a zero bubble enters stage 0 of every row.
  assign col_data = pop ? mem_q[rd_ptr_q] : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    skew_delay_line #(
      .STAGES (r + 1),
      .DATA_W (DATA_W)
    ) u_line (
      .clk_i   (clk),
      .rst_ni  (reset),
      .en_i    (run),
      .clr_i   (flush),
      .valid_i (pop),
      .data_i  (col_data[r*DATA_W +: DATA_W]),
      .valid_o (valid_out[r]),
      .data_o  (a_out[r*DATA_W +: DATA_W]),
      .busy_o  (row_busy[r])
    );
  end

  assign busy = !empty || (|row_busy);

endmodule
